// File: rtl/general_regfile_sb.sv
// general_regfile_sb: parametrised NUM_REGS x DATA_W register file.
// Two combinational read ports and one write port with an optional
// same-cycle bypass. A per-register pending-write scoreboard drives the
// ready flags. A sequenced engine clears one register per cycle.
module general_regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  src1_sel,
  input  logic [SEL_W-1:0]  src2_sel,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic              src1_ready,
  output logic              src2_ready,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pend_set,
  input  logic [SEL_W-1:0]  pend_sel,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int                IDX_W     = $clog2(NUM_REGS);
  localparam logic [SEL_W:0]    REG_LIMIT = (SEL_W + 1)'(NUM_REGS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  clr_state_e        state, state_next;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;

  logic wr_legal;
  logic pend_legal;

  // Selector addresses a physical register.
  function automatic logic in_range(input logic [SEL_W-1:0] sel);
    return {1'b0, sel} < REG_LIMIT;
  endfunction

  // Selector addresses a register that actually stores data.
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return in_range(sel) && !(ZERO_REG && sel == '0);
  endfunction

  // Writes and scoreboard sets are only accepted while the clear engine is idle.
  assign wr_legal   = wr_en    && (state == IDLE) && sel_valid(wr_sel);
  assign pend_legal = pend_set && (state == IDLE) && sel_valid(pend_sel);

  // Clear FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Clear FSM next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR:   if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    clr_busy = (state == CLEAR);
    clr_done = (state == DONE);
  end

  // Clear index: starts at 0 on entry, stops at the last register without wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  idx <= '0;
    else if (state != CLEAR)                     idx <= '0;
    else if (idx != LAST_IDX)                    idx <= idx + 1'b1;
  end

  // Register storage and scoreboard: clear engine has priority, otherwise write then set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the array is reset explicitly because the clear-on-reset state is architecturally visible.
      regs <= '{default: '0};
      pend <= '0;
    end else if (state == CLEAR) begin
      regs[idx] <= '0;
      pend[idx] <= 1'b0;
    end else begin
      if (wr_legal) begin
        regs[wr_sel[IDX_W-1:0]] <= wr_data;
        pend[wr_sel[IDX_W-1:0]] <= 1'b0;
      end
      // Later assignment wins: a new producer overrides the retiring one.
      if (pend_legal) pend[pend_sel[IDX_W-1:0]] <= 1'b1;
    end
  end

  // Read port 1 data with optional write-through forwarding.
  always_comb begin
    src1 = '0;
    if (sel_valid(src1_sel)) begin
      if (BYPASS && wr_legal && wr_sel == src1_sel) src1 = wr_data;
      else                                          src1 = regs[src1_sel[IDX_W-1:0]];
    end
  end

  // Read port 2 data with optional write-through forwarding.
  always_comb begin
    src2 = '0;
    if (sel_valid(src2_sel)) begin
      if (BYPASS && wr_legal && wr_sel == src2_sel) src2 = wr_data;
      else                                          src2 = regs[src2_sel[IDX_W-1:0]];
    end
  end

  // Ready flags: blocked during a clear, forwarded writes count as ready.
  always_comb begin
    src1_ready = 1'b0;
    src2_ready = 1'b0;
    if (state != CLEAR) begin
      if (!in_range(src1_sel)) src1_ready = 1'b1;
      else src1_ready = !pend[src1_sel[IDX_W-1:0]] ||
                        (BYPASS && wr_legal && wr_sel == src1_sel);
      if (!in_range(src2_sel)) src2_ready = 1'b1;
      else src2_ready = !pend[src2_sel[IDX_W-1:0]] ||
                        (BYPASS && wr_legal && wr_sel == src2_sel);
    end
  end

endmodule
